udiv_seq: RTL and testbench

Parametrised sequential unsigned divider for the ALU arithmetic unsigned path. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor using restoring division, retiring STEPS quotient bits per clock. It replaces the fully unrolled combinational divider array wherever area matters more than single-cycle latency. Operands are accepted and results delivered through valid/ready handshakes, so it drops into the ALU result mux or a multi-cycle issue slot.

---
 rtl/udiv_pkg.sv | 22 ++
 rtl/udiv_seq_if.sv | 27 ++
 rtl/udiv_step.sv | 25 ++
 rtl/udiv_seq.sv | 113 +++++++++++
 tb/tb_udiv_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/udiv_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// parameter legality and counter sizing.
package udiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } udiv_state_e;

    function automatic bit udiv_params_ok(input int width, input int steps);
        return (width >= 2) && (steps inside {1, 2, 4, 8}) && (width % steps == 0);
    endfunction

    // Iteration counter holds WIDTH/STEPS-1 down to 0; never narrower than one bit.
    function automatic int udiv_cnt_w(input int width, input int steps);
        int n;
        n = width / steps;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/udiv_seq_if.sv
// Operand/result handshake bundle for udiv_seq; master issues operands and
// consumes results, slave is the divider.
interface udiv_seq_if
    import udiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/udiv_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module udiv_step
    import udiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_bit_o
);
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;

    // The partial remainder stays below the divisor, so the kept result always
    // fits WIDTH bits; only the trial difference needs the extra sign bit.
    always_comb begin
        r_sh    = {r_i, q_msb_i};
        trial   = r_sh - {1'b0, d_i};
        q_bit_o = ~trial[WIDTH];
        r_o     = q_bit_o ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
    end
endmodule

// File: rtl/udiv_seq.sv
// Sequential unsigned divider: STEPS chained restoring steps per clock,
// valid/ready on both sides, synchronous flush, zero-divisor shortcut.
module udiv_seq
    import udiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    udiv_seq_if.slave  bus
);
    localparam int               CNT_W    = udiv_cnt_w(WIDTH, STEPS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH / STEPS - 1);

    if (!udiv_params_ok(WIDTH, STEPS)) begin : g_bad_params
        $error("udiv_seq: WIDTH must be >= 2 and divisible by STEPS in {1,2,4,8}");
    end

    udiv_state_e      state_q;
    logic             in_ready_q, out_valid_q, dbz_q, zero_q;
    logic [WIDTH-1:0] q_q, r_q, d_q, quot_q, rem_q;
    logic [CNT_W-1:0] cnt_q;

    logic [STEPS:0][WIDTH-1:0] q_d, r_d;
    logic [STEPS-1:0]          q_bit;

    assign q_d[0] = q_q;
    assign r_d[0] = r_q;

    for (genvar s = 0; s < STEPS; s++) begin : g_step
        udiv_step #(.WIDTH(WIDTH)) u_step (
            .r_i     (r_d[s]),
            .q_msb_i (q_d[s][WIDTH-1]),
            .d_i     (d_q),
            .r_o     (r_d[s+1]),
            .q_bit_o (q_bit[s])
        );
        assign q_d[s+1] = {q_d[s][WIDTH-2:0], q_bit[s]};
    end

    // Results are copied into the output registers on the first DONE cycle, so
    // they stay frozen under backpressure regardless of the working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            zero_q      <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        d_q        <= bus.divisor;
                        if (bus.divisor == '0) begin
                            state_q <= DONE;
                            zero_q  <= 1'b1;
                            q_q     <= '1;
                            r_q     <= bus.dividend;
                        end else begin
                            state_q <= CALC;
                            zero_q  <= 1'b0;
                            q_q     <= bus.dividend;
                            r_q     <= '0;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                CALC: begin
                    q_q <= q_d[STEPS];
                    r_q <= r_d[STEPS];
                    if (cnt_q == '0) state_q <= DONE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        quot_q      <= q_q;
                        rem_q       <= r_q;
                        dbz_q       <= zero_q;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_udiv_seq.sv
// Self-checking bench for udiv_seq: one STEPS=1 and one STEPS=4 instance,
// directed vector table, corner-case sequences and random checks.
module tb_udiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;

    int n_cmp = 0;
    int n_err = 0;

    udiv_seq_if #(.WIDTH(W)) bus1 ();
    udiv_seq_if #(.WIDTH(W)) bus4 ();

    assign bus1.in_valid  = in_valid & ~sel;
    assign bus1.dividend  = dividend;
    assign bus1.divisor   = divisor;
    assign bus1.out_ready = out_ready & ~sel;
    assign bus4.in_valid  = in_valid & sel;
    assign bus4.dividend  = dividend;
    assign bus4.divisor   = divisor;
    assign bus4.out_ready = out_ready & sel;

    logic         o_valid, o_ready, o_dbz;
    logic [W-1:0] o_q, o_r;
    assign o_valid = sel ? bus4.out_valid   : bus1.out_valid;
    assign o_ready = sel ? bus4.in_ready    : bus1.in_ready;
    assign o_dbz   = sel ? bus4.div_by_zero : bus1.div_by_zero;
    assign o_q     = sel ? bus4.quotient    : bus1.quotient;
    assign o_r     = sel ? bus4.remainder   : bus1.remainder;

    udiv_seq #(.WIDTH(W), .STEPS(1)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1));
    udiv_seq #(.WIDTH(W), .STEPS(4)) dut4 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus4));

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         s;
        logic [W-1:0] a, b, q, r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                           input int elat);
        int lat;
        check({nm, "/in_ready"}, 64'(o_ready), 64'(1));
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({nm, "/latency"}, 64'(lat), 64'(elat));
        check({nm, "/quotient"}, 64'(o_q), 64'(eq));
        check({nm, "/remainder"}, 64'(o_r), 64'(er));
        check({nm, "/div_by_zero"}, 64'(o_dbz), 64'(ez));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, "/released"}, 64'({o_valid, o_ready}), 64'(2'b01));
    endtask

    task automatic expect_quiet(input string nm, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (o_valid) seen = 1'b1;
        end
        check(nm, 64'(seen), 64'(0));
    endtask

    task automatic run_random(input int n);
        logic [W-1:0] a, b, eq, er;
        int mode;
        for (int i = 0; i < n; i++) begin
            a    = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 255));
                3:       b = a;
                4:       b = a + 1;
                5:       a = W'($urandom_range(0, 1000));
                default: b = $urandom;
            endcase
            if (mode == 5) b = $urandom;
            if (b == '0) begin
                eq = '1;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_div($sformatf("rand%0d_s%0d", i, sel), a, b, eq, er, b == '0,
                    (b == '0) ? 1 : (sel ? 9 : 33));
        end
    endtask

    initial begin
        vt[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        vt[1] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
        vt[2] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 33};
        vt[3] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
        vt[4] = '{1'b0, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1, 1};
        vt[5] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
        vt[6] = '{1'b1, 32'h8000_0000,  32'h10,         32'h0800_0000,  32'd0,          1'b0, 9};
        vt[7] = '{1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0, 9};
        vt[8] = '{1'b1, 32'hDEAD_BEEF,  32'd0,          32'hFFFF_FFFF,  32'hDEAD_BEEF,  1'b1, 1};
        vt[9] = '{1'b1, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0, 9};

        // Reset state of both instances.
        #12;
        check("reset/s1", 64'({bus1.in_ready, bus1.out_valid, bus1.div_by_zero, bus1.quotient, bus1.remainder}),
              64'(1'b1) << 66 >> 0 == 0 ? 64'd0 : 64'd0);
        check("reset/s1_ctrl", 64'({bus1.in_ready, bus1.out_valid, bus1.div_by_zero}), 64'(3'b100));
        check("reset/s1_data", 64'({bus1.quotient, bus1.remainder}), 64'(0));
        check("reset/s4_ctrl", 64'({bus4.in_ready, bus4.out_valid, bus4.div_by_zero}), 64'(3'b100));
        check("reset/s4_data", 64'({bus4.quotient, bus4.remainder}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            sel = vt[i].s;
            run_div($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].z, vt[i].lat);
        end

        // Backpressure: result held, no accept while DONE.
        sel = 1'b0;
        dividend = 32'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !o_valid; k++) tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp/hold%0d", k), 64'({o_valid, o_ready, o_q, o_r}),
                  64'({1'b1, 1'b0, 32'd14, 32'd2}) );
            dividend = 32'd9;
            divisor  = 32'd9;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("bp/hold_last", 64'({o_valid, o_ready, o_q}), 64'({1'b1, 1'b0, 32'd14}));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp/released", 64'({o_valid, o_ready}), 64'(2'b01));
        expect_quiet("bp/no_extra_result", 40);

        // Flush in the middle of CALC, then a fresh operation.
        dividend = 32'd12345;
        divisor  = 32'd67;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush/idle", 64'({o_valid, o_ready}), 64'(2'b01));
        expect_quiet("flush/no_result", 40);
        run_div("flush/1000div3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

        // Flush in the accept cycle discards the operands.
        dividend = 32'd77;
        divisor  = 32'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_acc/idle", 64'({o_valid, o_ready}), 64'(2'b01));
        expect_quiet("flush_acc/no_result", 40);

        run_random(200);

        sel = 1'b1;
        run_random(2000);

        // Asynchronous reset mid-CALC after a zero-divisor result left outputs nonzero.
        run_div("rst/pre", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        dividend = 32'd1000;
        divisor  = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst/ctrl", 64'({o_ready, o_valid, o_dbz}), 64'(3'b100));
        check("rst/data", 64'({o_q, o_r}), 64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        check("rst/after_release", 64'({o_valid, o_ready}), 64'(2'b01));
        run_div("rst/1000div3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
